// File: rtl/ram_fifo_ctrl.sv
// Stream FIFO controller for an external dual-port RAM with registered read address,
// with a two-entry output skid buffer. Optional watermark output: RAM_FIFO_WATERMARK_EN.
module ram_fifo_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
`ifdef RAM_FIFO_WATERMARK_EN
  , parameter int AF_THRESH = (1 << ADDR_W) - 4
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [ADDR_W+1:0] o_count,
  output logic              o_empty
`ifdef RAM_FIFO_WATERMARK_EN
  , output logic            o_almost_full
`endif
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(1 << ADDR_W);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   ram_cnt;
  logic              pend;
  logic [1:0]        skid_cnt;
  logic [DATA_W-1:0] skid [2];

  logic              push;
  logic              pop;
  logic              fetch;
  logic [2:0]        occ;
  logic [1:0]        slot;

  assign s_ready     = (ram_cnt != FULL_CNT);
  assign push        = s_valid & s_ready;
  // Held low while reset is asserted even if the producer is already offering data.
  assign ram_wr_en   = push & rst;
  assign ram_wr_addr = wr_ptr;
  assign ram_wr_data = s_data;

  assign m_valid     = (skid_cnt != 2'd0);
  assign pop         = m_valid & m_ready;
  assign m_data      = skid[0];

  // Skid occupancy once the in-flight word lands and this cycle's pop leaves.
  assign occ         = 3'(skid_cnt) + 3'(pend) - 3'(pop);
  assign fetch       = (ram_cnt != '0) && (occ < 3'd2);
  assign ram_rd_en   = fetch;
  assign ram_rd_addr = rd_ptr;

  assign slot        = skid_cnt - 2'(pop);

  assign o_count     = (ADDR_W+2)'(ram_cnt) + (ADDR_W+2)'(pend) + (ADDR_W+2)'(skid_cnt);
  assign o_empty     = (o_count == '0);
`ifdef RAM_FIFO_WATERMARK_EN
  assign o_almost_full = (o_count >= (ADDR_W+2)'(AF_THRESH));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      pend     <= 1'b0;
      skid_cnt <= 2'd0;
      skid[0]  <= '0;
      skid[1]  <= '0;
    end else if (i_flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      pend     <= 1'b0;
      skid_cnt <= 2'd0;
    end else begin
      // RAM address stage: pointers and occupancy.
      if (push)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (fetch)
        rd_ptr <= rd_ptr + ADDR_W'(1);
      ram_cnt <= ram_cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(fetch);
      pend    <= fetch;

      // Skid stage: shift on pop, then land the RAM word in the first free slot.
      skid_cnt <= slot + 2'(pend);
      if (pop)
        skid[0] <= skid[1];
      if (pend) begin
        if (slot == 2'd0)
          skid[0] <= ram_rd_data;
        else
          skid[1] <= ram_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl (ADDR_W=4) with a queue-based occupancy/order model
// and a behavioural RAM; watermark checks follow RAM_FIFO_WATERMARK_EN.
module tb_ram_fifo_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int AF     = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_flush = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic [ADDR_W+1:0] o_count;
  logic              o_empty;
`ifdef RAM_FIFO_WATERMARK_EN
  logic              o_almost_full;
`endif

  ram_fifo_ctrl #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
`ifdef RAM_FIFO_WATERMARK_EN
    , .AF_THRESH(AF)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_flush(i_flush),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .ram_wr_en(ram_wr_en),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data),
    .ram_rd_en(ram_rd_en),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .o_count(o_count),
    .o_empty(o_empty)
`ifdef RAM_FIFO_WATERMARK_EN
    , .o_almost_full(o_almost_full)
`endif
  );

  always #5 clk = ~clk;

  // External RAM: synchronous write, registered read address.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_q = '0;
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) rd_q <= ram_rd_addr;
  end
  assign ram_rd_data = mem[rd_q];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: words held, in order; write-address count since the last clear.
  logic [DATA_W-1:0] mq[$];
  int wr_cnt = 0;
  int acc_edge[$];
  int pop_edge[$];
  int mv_edge = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      mq.delete();
      wr_cnt = 0;
    end else begin
      chk("o_count", 32'(o_count), 32'(mq.size()));
      chk("o_empty", 32'(o_empty), 32'(mq.size() == 0));
      if (mq.size() < DEPTH) chk("s_ready_room", 32'(s_ready), 32'd1);
      if (mq.size() == DEPTH + 2) chk("s_ready_cap", 32'(s_ready), 32'd0);
      if (mq.size() == 0) chk("m_valid_empty", 32'(m_valid), 32'd0);
      chk("ram_wr_en", 32'(ram_wr_en), 32'(s_valid & s_ready));
      if (ram_wr_en) chk("ram_wr_addr", 32'(ram_wr_addr), 32'(wr_cnt % DEPTH));
`ifdef RAM_FIFO_WATERMARK_EN
      chk("almost_full", 32'(o_almost_full), 32'(mq.size() >= AF));
`endif
      if (mv_edge < 0 && m_valid) mv_edge = cyc;
      if (i_flush) begin
        mq.delete();
        wr_cnt = 0;
      end else begin
        if (m_valid && m_ready && mq.size() > 0) begin
          chk("m_data_order", 32'(m_data), 32'(mq[0]));
          void'(mq.pop_front());
          pop_edge.push_back(cyc + 1);
        end
        if (s_valid && s_ready) begin
          mq.push_back(s_data);
          wr_cnt++;
          acc_edge.push_back(cyc + 1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && !o_empty; i++) step();
    chk("drain_done", 32'(o_empty), 32'd1);
  endtask

  task automatic fill(input logic [DATA_W-1:0] base, output int n);
    n = 0;
    m_ready = 1'b0;
    for (int g = 0; g < 40 && s_ready; g++) begin
      s_valid = 1'b1;
      s_data  = base + DATA_W'(n);
      step();
      n++;
    end
    s_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_o_count"}, 32'(o_count), 32'd0);
    chk({tag, "_o_empty"}, 32'(o_empty), 32'd1);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_ram_wr_en"}, 32'(ram_wr_en), 32'd0);
    chk({tag, "_ram_rd_en"}, 32'(ram_rd_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(ram_wr_addr), 32'd0);
    chk({tag, "_rd_addr"}, 32'(ram_rd_addr), 32'd0);
    chk({tag, "_m_data"}, 32'(m_data), 32'd0);
`ifdef RAM_FIFO_WATERMARK_EN
    chk({tag, "_almost_full"}, 32'(o_almost_full), 32'd0);
`endif
  endtask

  initial begin
    int n;

    // Reset and idle.
    #2;
    check_reset_outputs("rst_init");
    step();
    step();
    rst = 1'b1;
    step();
    step();
    chk("idle_s_ready", 32'(s_ready), 32'd1);
    chk("idle_rd_en", 32'(ram_rd_en), 32'd0);

    // Five words back-to-back with the consumer always ready.
    m_ready = 1'b1;
    acc_edge.delete();
    pop_edge.delete();
    mv_edge = -1;
    for (int i = 1; i <= 5; i++) begin
      s_valid = 1'b1;
      s_data  = DATA_W'(i);
      step();
    end
    s_valid = 1'b0;
    wait_empty(20);
    chk("first_latency", 32'(mv_edge - acc_edge[0]), 32'd2);
    chk("pop_count", 32'(pop_edge.size()), 32'd5);
    for (int i = 0; i < 5 && i < pop_edge.size(); i++)
      chk("pop_rate", 32'(pop_edge[i] - acc_edge[0]), 32'(3 + i));

    // Fill to capacity, then drain across the pointer wrap.
    fill(16'h0100, n);
    step();
    chk("fill_words", 32'(n), 32'd18);
    chk("fill_count", 32'(o_count), 32'd18);
    chk("fill_s_ready", 32'(s_ready), 32'd0);
    chk("fill_wr_addr", 32'(ram_wr_addr), 32'd7);
`ifdef RAM_FIFO_WATERMARK_EN
    chk("fill_af", 32'(o_almost_full), 32'd1);
`endif
    m_ready = 1'b1;
    wait_empty(60);
    chk("drain_rd_addr", 32'(ram_rd_addr), 32'd7);

    // Full: pop and push offered together; push refused, room appears next cycle.
    fill(16'h0200, n);
    s_valid = 1'b1;
    s_data  = 16'hBEEF;
    m_ready = 1'b1;
    chk("full_s_ready_pre", 32'(s_ready), 32'd0);
    step();
    chk("full_s_ready_post", 32'(s_ready), 32'd1);
    chk("full_count_post", 32'(o_count), 32'd17);
    m_ready = 1'b0;
    step();
    s_valid = 1'b0;
    chk("full_count_refill", 32'(o_count), 32'd18);
    m_ready = 1'b1;
    wait_empty(60);

    // Flush with a read in flight and a same-cycle push offered.
    m_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      s_valid = 1'b1;
      s_data  = 16'h0300 + DATA_W'(i);
      step();
    end
    chk("preflush_count", 32'(o_count), 32'd3);
    chk("preflush_m_valid", 32'(m_valid), 32'd1);
    s_data  = 16'hDEAD;
    i_flush = 1'b1;
    m_ready = 1'b1;
    step();
    i_flush = 1'b0;
    s_valid = 1'b0;
    chk("flush_count", 32'(o_count), 32'd0);
    chk("flush_m_valid", 32'(m_valid), 32'd0);
    s_valid = 1'b1;
    s_data  = 16'h03A1;
    step();
    s_valid = 1'b0;
    step();
    step();
    chk("postflush_m_valid", 32'(m_valid), 32'd1);
    chk("postflush_m_data", 32'(m_data), 32'h03A1);
    wait_empty(20);

    // Asynchronous reset mid-operation.
    m_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      s_valid = 1'b1;
      s_data  = 16'h0400 + DATA_W'(i);
      step();
    end
    step();
    chk("premid_m_valid", 32'(m_valid), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    s_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    step();
    chk("after_rst_count", 32'(o_count), 32'd0);
    chk("after_rst_m_valid", 32'(m_valid), 32'd0);
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'h0555;
    step();
    s_valid = 1'b0;
    wait_empty(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
